// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter that sits beside data memory.
// Register window at BASE_ADDR:
//   +0 TXDATA: a write queues WriteData[7:0]; a read returns 0.
//   +4 STATUS: a read returns {parity_cap, count, ovf, empty, full, busy}.
//              A write with WriteData[3] set clears ovf.
// A small TX FIFO lets stores complete without stalling the core. The FIFO
// drains into an 8N1 serial shifter.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit before the
// stop bit and sets STATUS bit 7.
//
// state  | meaning
// IDLE   | line idle high, waiting for a queued byte
// START  | start bit (low) for one bit time
// DATA   | eight data bits, LSB first
// PARITY | even parity bit (UART_TX_PARITY_EN builds only)
// STOP   | stop bit (high); pops the next byte directly if one is queued
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic        rd_hit,
  output logic [31:0] rd_data,
  output logic        tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  localparam logic PARITY_CAP = 1'b1;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  localparam logic PARITY_CAP = 1'b0;
`endif

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic            tx_q, tx_d;
  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [7:0]      fifo_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;

  logic            hit, push_req, clr_ovf, push_ok, pop;
  logic            empty, full, busy, baud_done;
  logic [31:0]     count_ext, status;
  logic            unused_bits;

  assign hit       = (ALUResult[31:3] == BASE_ADDR[31:3]);
  assign push_req  = MemWrite && hit && !ALUResult[2];
  assign clr_ovf   = MemWrite && hit && ALUResult[2] && WriteData[3];
  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign busy      = (state_q != S_IDLE);
  assign baud_done = (baud_q == BAUD_LAST);

  // FIFO bookkeeping; a push into a full FIFO still lands if a pop frees a slot on the same edge
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    push_ok  = push_req && (!full || pop);
    if (push_ok) begin
      fifo_d[wr_ptr_q] = WriteData[7:0];
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push_req && !push_ok) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // Serial framing FSM; tx is registered from the next state so the line never glitches
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    data_d  = data_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          data_d  = fifo_q[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            data_d  = fifo_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
      end
    endcase

    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_d[bit_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = ^data_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // Control and pointer registers; reset abandons any frame in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage needs no reset; count gates every read of it
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign count_ext   = 32'(count_q);
  assign status      = {24'd0, PARITY_CAP, count_ext[2:0], ovf_q, empty, full, busy};
  assign rd_hit      = hit;
  assign rd_data     = (hit && ALUResult[2]) ? status : 32'd0;
  assign tx          = tx_q;
  assign unused_bits = ^{ALUResult[1:0], WriteData[31:8], count_ext[31:3]};

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Testbench for uart_tx_mmio with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// The reference model tracks frames as "cycles into the current frame" over a byte queue.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam int C = 4;
  localparam int D = 4;
`ifdef UART_TX_PARITY_EN
  localparam int  FRAME = 11 * C;
  localparam logic PAR  = 1'b1;
`else
  localparam int  FRAME = 10 * C;
  localparam logic PAR  = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic        rd_hit;
  logic [31:0] rd_data;
  logic        tx;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] q[$];
  logic       active;
  int         t;
  logic [7:0] cur;
  logic       m_ovf;

  uart_tx_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
    .WriteData(WriteData), .rd_hit(rd_hit), .rd_data(rd_data), .tx(tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    active = 1'b0;
    t      = 0;
    cur    = 8'h00;
    m_ovf  = 1'b0;
  endtask

  task automatic model_edge(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    logic popped;
    logic mhit;
    int   pre;
    popped = 1'b0;
    mhit   = ((addr >> 3) == (BASE >> 3));
    pre    = q.size();
    if (active) begin
      if (t == FRAME - 1) begin
        if (pre > 0) begin
          cur = q.pop_front(); t = 0; popped = 1'b1;
        end else begin
          active = 1'b0; t = 0;
        end
      end else begin
        t++;
      end
    end else if (pre > 0) begin
      cur = q.pop_front(); active = 1'b1; t = 0; popped = 1'b1;
    end
    if (wr && mhit && !addr[2]) begin
      if (pre < D || popped) q.push_back(data[7:0]);
      else m_ovf = 1'b1;
    end
    if (wr && mhit && addr[2] && data[3]) m_ovf = 1'b0;
  endtask

  function automatic logic exp_tx();
    int b;
    if (!active) return 1'b1;
    b = t / C;
    if (b == 0) return 1'b0;
    if (b <= 8) return cur[b-1];
    if (PAR && b == 9) return ^cur;
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [2:0] cnt;
    cnt = 3'(q.size());
    return {24'd0, PAR, cnt, m_ovf, (q.size() == 0), (q.size() == D), active};
  endfunction

  // One clock: drive a bus access for the edge, then read STATUS and tx after it
  task automatic step(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    MemWrite  = wr;
    ALUResult = addr;
    WriteData = data;
    @(posedge clk);
    model_edge(wr, addr, data);
    #1;
    MemWrite  = 1'b0;
    ALUResult = BASE + 32'd4;
    #1;
    check("tx", {31'd0, tx}, {31'd0, exp_tx()});
    check("status", rd_data, exp_status());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, BASE + 32'd4, 32'd0);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    MemWrite  = 1'b0;
    ALUResult = BASE + 32'd4;
    @(posedge clk);
    model_clear();
    #1;
    reset = 1'b0;
    #1;
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_status", rd_data, {24'd0, PAR, 7'h04});
  endtask

  initial begin
    int busy_cycles;
    logic [31:0] a;
    int r;
    reset     = 1'b1;
    MemWrite  = 1'b0;
    ALUResult = 32'd0;
    WriteData = 32'd0;
    model_clear();

    // 1: single byte 0xA5, full frame checked bit by bit; frame length measured via busy
    do_reset();
    step(1'b1, BASE, 32'h0000_00A5);
    busy_cycles = 0;
    for (int i = 0; i < FRAME + 8; i++) begin
      step(1'b0, BASE + 32'd4, 32'd0);
      if (rd_data[0]) busy_cycles++;
    end
    check("frame_len", 32'(busy_cycles), 32'(FRAME));

    // 2: five back-to-back stores while idle; contiguous frames, no overflow
    for (int i = 1; i <= 5; i++) step(1'b1, BASE, 32'(i));
    check("no_ovf_after_5", {31'd0, rd_data[3]}, 32'd0);
    idle(5 * FRAME + 6);

    // 3: overfill during a frame, then clear ovf
    for (int i = 0; i < 6; i++) step(1'b1, BASE, 32'h0000_0030 + 32'(i));
    check("status_ovf_full", rd_data, {24'd0, PAR, 7'h4B});
    step(1'b1, BASE + 32'd4, 32'h0000_0008);
    check("ovf_cleared", {31'd0, rd_data[3]}, 32'd0);
    idle(5 * FRAME + 6);

    // 4: address decode and read mux
    ALUResult = BASE + 32'd4; #1;
    check("rd_hit_status", {31'd0, rd_hit}, 32'd1);
    check("rd_status_idle", rd_data, {24'd0, PAR, 7'h04});
    ALUResult = BASE + 32'd7; #1;
    check("rd_status_low_bits_ignored", rd_data, {24'd0, PAR, 7'h04});
    ALUResult = BASE; #1;
    check("rd_hit_txdata", {31'd0, rd_hit}, 32'd1);
    check("rd_txdata_zero", rd_data, 32'd0);
    ALUResult = BASE + 32'd8; #1;
    check("rd_hit_miss", {31'd0, rd_hit}, 32'd0);
    check("rd_data_miss", rd_data, 32'd0);

    // 5: reset mid-DATA with two bytes queued
    step(1'b1, BASE, 32'h11);
    step(1'b1, BASE, 32'h22);
    step(1'b1, BASE, 32'h33);
    idle(10);
    do_reset();
    idle(FRAME + 20);

    // 6: byte 0x07 (odd popcount: parity bit 1 in parity builds)
    step(1'b1, BASE, 32'h07);
    check("parity_flag", {31'd0, rd_data[7]}, {31'd0, PAR});
    idle(FRAME + 4);

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 14) begin
        a = BASE + 32'($urandom_range(0, 3));
        step(1'b1, a, $urandom);
      end else if (r < 18) begin
        step(1'b1, BASE + 32'd4 + 32'($urandom_range(0, 3)), $urandom);
      end else if (r < 22) begin
        a = $urandom;
        if ((a >> 3) == (BASE >> 3)) a = BASE + 32'd8;
        step(1'b1, a, $urandom);
      end else begin
        step(1'b0, BASE, 32'd0);
      end
    end
    idle(5 * FRAME + 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
